// File: rtl/decode_sequencer.sv
// decode_sequencer
//   Buffers fetched instructions in a DEPTH-entry FIFO and feeds them one at a
//   time to an external combinational immediate generator. The head instruction,
//   its PC and the generated immediate are captured into an output register that
//   is handed to rename/dispatch over a valid/ready handshake.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   fetch_valid/ready/instr/pc  fetch-side handshake and payload
//   flush                       single-cycle squash of all buffered work
//   imm_instr / imm_value       drive to / result from the immediate generator
//   dec_valid/ready/instr/pc/imm  decoded output handshake and payload
//   occupancy                   current FIFO entry count
//   stall_count                 saturating count of back-pressured cycles
module decode_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fetch_valid,
  output logic                   fetch_ready,
  input  logic [XLEN-1:0]        fetch_instr,
  input  logic [XLEN-1:0]        fetch_pc,
  input  logic                   flush,
  output logic [XLEN-1:0]        imm_instr,
  input  logic [XLEN-1:0]        imm_value,
  output logic                   dec_valid,
  input  logic                   dec_ready,
  output logic [XLEN-1:0]        dec_instr,
  output logic [XLEN-1:0]        dec_pc,
  output logic [XLEN-1:0]        dec_imm,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [15:0]            stall_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);
  localparam logic [XLEN-1:0] Nop  = XLEN'(32'h0000_0013);

  logic [XLEN-1:0] mem_instr_q [DEPTH];
  logic [XLEN-1:0] mem_pc_q    [DEPTH];

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic            dec_valid_q, dec_valid_d;
  logic [XLEN-1:0] dec_instr_q, dec_pc_q, dec_imm_q;
  logic [15:0]     stall_q, stall_d;

  logic push, pop;

  always_comb begin
    fetch_ready = (count_q != Full);
    push        = fetch_valid & fetch_ready & ~flush;
    pop         = (count_q != '0) & (~dec_valid_q | dec_ready) & ~flush;

    // Only the registered head feeds the generator; fetch never reaches it.
    imm_instr = (count_q != '0) ? mem_instr_q[rd_ptr_q] : Nop;

    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;

    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    dec_valid_d = dec_valid_q;
    if (pop) begin
      dec_valid_d = 1'b1;
    end else if (dec_ready) begin
      dec_valid_d = 1'b0;
    end

    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      dec_valid_d = 1'b0;
    end

    // Flush deliberately leaves the stall statistic alone.
    stall_d = stall_q;
    if (dec_valid_q && !dec_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      dec_valid_q <= 1'b0;
      dec_instr_q <= '0;
      dec_pc_q    <= '0;
      dec_imm_q   <= '0;
      stall_q     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_instr_q[i] <= '0;
        mem_pc_q[i]    <= '0;
      end
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      dec_valid_q <= dec_valid_d;
      stall_q     <= stall_d;
      if (push) begin
        mem_instr_q[wr_ptr_q] <= fetch_instr;
        mem_pc_q[wr_ptr_q]    <= fetch_pc;
      end
      // Data fields are only written on pop and hold while invalid.
      if (pop) begin
        dec_instr_q <= mem_instr_q[rd_ptr_q];
        dec_pc_q    <= mem_pc_q[rd_ptr_q];
        dec_imm_q   <= imm_value;
      end
    end
  end

  assign dec_valid   = dec_valid_q;
  assign dec_instr   = dec_instr_q;
  assign dec_pc      = dec_pc_q;
  assign dec_imm     = dec_imm_q;
  assign occupancy   = count_q;
  assign stall_count = stall_q;

endmodule

// File: doc/decode_sequencer.md
# decode_sequencer

Buffers fetched instructions in a small FIFO and sequences them one at a time through the shared `immediate_generate` decode resource. It presents each instruction to the generator's `instruction` input and captures the resulting `immediate` together with the instruction and its PC into an output register. The output register feeds the rename/dispatch stage over a valid/ready handshake. The block sits between fetch and rename in the front end and supports a single-cycle pipeline flush.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `XLEN`, 32, instruction/PC/immediate width.
- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `fetch_valid` in 1: fetch offers an instruction.
- `fetch_ready` out 1: FIFO can accept this cycle.
- `fetch_instr` in XLEN: raw instruction.
- `fetch_pc` in XLEN: instruction PC.
- `flush` in 1: synchronous squash of all buffered work.
- `imm_instr` out XLEN: drives `immediate_generate.instruction`.
- `imm_value` in XLEN: from `immediate_generate.immediate` (combinational).
- `dec_valid` out 1: output register holds a decoded instruction.
- `dec_ready` in 1: downstream accepts this cycle.
- `dec_instr` out XLEN: registered instruction.
- `dec_pc` out XLEN: registered PC.
- `dec_imm` out XLEN: registered immediate.
- `occupancy` out log2(DEPTH)+1: FIFO entry count.
- `stall_count` out 16: saturating count of back-pressure cycles.

## Operation
- **FIFO.** Circular buffer with read/write pointers of log2(DEPTH) bits, wrapping modulo DEPTH, plus a count register.
- **Push.** `push = fetch_valid & fetch_ready & ~flush`. `fetch_ready = (count != DEPTH)`; it does not look ahead at a same-cycle pop.
- **Resource drive.** `imm_instr` = head entry's instruction when count > 0, else `32'h00000013` (NOP). The output is combinational from FIFO state; there is no combinational path from `fetch_*` to it.
- **Pop.** `pop = (count != 0) & (~dec_valid | dec_ready) & ~flush`.
- **Output register load.** On pop, the output register loads head instruction, head PC and `imm_value`, and `dec_valid` is set to 1.
- **Output register clear.** If there is no pop and `dec_ready` is high, `dec_valid` is cleared to 0. Data fields hold their last value while invalid.
- **Count update.** Count is +1 on push only, −1 on pop only, and unchanged on simultaneous push and pop.
- **Flush.** Highest priority after reset. At the next edge: count=0, both pointers=0, `dec_valid`=0. Any fetch handshake in the flush cycle is discarded. `stall_count` is not cleared.
- **stall_count.** Increments on each cycle with `dec_valid & ~dec_ready`. Saturates at 16'hFFFF. Cleared only by reset.
- **Reset values.** `dec_valid`=0, `dec_instr`=`dec_pc`=`dec_imm`=0, `occupancy`=0, `stall_count`=0. `fetch_ready`=1 and `imm_instr`=`32'h00000013` in the first cycle after reset.
- **Reset mid-operation.** Reset behaves identically to flush and additionally zeroes all data registers and `stall_count`.

## Timing
- **Latency.** An instruction handshaked on fetch in cycle N sits at the FIFO head in N+1. It is loaded into the output register at the end of N+1, and `dec_valid` is high in N+2. Minimum latency is 2 cycles.
- **Throughput.** One instruction per cycle when `dec_ready` is held high and fetch streams continuously.
- **Back-pressure.** With `dec_ready`=0, the FIFO fills and `fetch_ready` drops in the cycle after count reaches DEPTH.
- **Handshake stability.** While `dec_valid & ~dec_ready`, all `dec_*` outputs hold stable.
- **Resource sampling.** `imm_value` is sampled only at the pop edge. The generator must settle within one cycle of a head change.

## Test plan
- **Reset.** Assert `reset` for 2 cycles mid-stream → `dec_valid`=0, `occupancy`=0, `stall_count`=0, `fetch_ready`=1, `imm_instr`=`0x00000013`.
- **Single instruction.** With a real `immediate_generate` instance, push `0x00600113` at PC `0x100` in cycle 0, `dec_ready`=1 → in cycle 2, `dec_valid`=1, `dec_imm`=6, `dec_pc`=`0x100`.
- **Streaming.** Push `0x00400113`, `0x12345037`, `0xFFF00093` back-to-back → `dec_imm` is 4, `0x12345000`, `0xFFFFFFFF` in consecutive cycles 2–4, in order.
- **Full and back-pressure.** Hold `dec_ready`=0 and push 6 instructions with DEPTH=4 → only 5 are accepted (1 in the output register + 4 in the FIFO). `fetch_ready`=0 with `occupancy`=4. `stall_count` increments every stalled cycle. Releasing `dec_ready` drains the instructions in order, one per cycle.
- **Flush.** Load 3 entries, then assert `flush` together with `fetch_valid` → next cycle `occupancy`=0 and `dec_valid`=0. The flush-cycle instruction never appears; the next push appears 2 cycles after its handshake.
- **Wrap-around.** Run 20 pushes and pops with randomized `dec_ready` → output order and PCs match the input order exactly across pointer wrap. `stall_count` equals the number of `dec_valid & ~dec_ready` cycles.
